wb_arbiter: RTL and testbench

//  Shares the single register-file write port of the pipelined core between NUM_REQ write-back

---
 rtl/core_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath widths, register count and write-back requester indices.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;
    localparam int NUM_WB = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer,
// searching upward with wrap-around; the pointer moves past the winner on an accepted grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx_hi;
    logic [PW-1:0] idx_any;
    logic [PW-1:0] grant_idx;
    logic          hit_hi;
    logic          hit_any;

    // Downward scan leaves the lowest index in each candidate; the "hi" candidate
    // only considers requesters at or above the pointer, the other covers the wrap.
    always_comb begin
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                hit_any = 1'b1;
                idx_any = PW'(k);
                if (k >= int'(ptr_q)) begin
                    hit_hi = 1'b1;
                    idx_hi = PW'(k);
                end
            end
        end
        grant_idx = hit_hi ? idx_hi : idx_any;
        o_grant   = '0;
        if (hit_any) begin
            o_grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_nxt = ptr_q;
        if (i_advance && hit_any) begin
            ptr_nxt = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between execute units and
// tracks in-flight destinations in a busy scoreboard that drives the issue stall.
module wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*AW-1:0]   i_req_rd_addr,
    input  logic [NUM_REQ*XLEN-1:0] i_req_rd_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic                    o_write_en,
    output logic [AW-1:0]           o_rd_addr,
    output logic [XLEN-1:0]         o_rd_data,
    input  logic                    i_alloc_en,
    input  logic [AW-1:0]           i_alloc_rd_addr,
    input  logic [AW-1:0]           i_rs1_addr,
    input  logic [AW-1:0]           i_rs2_addr,
    output logic                    o_stall,
    output logic [31:0]             o_busy
);

    import core_pkg::*;

    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic [AW-1:0]       sel_addr;
    logic [XLEN-1:0]     sel_data;
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .i_advance (accept),
        .o_grant   (grant)
    );

    assign o_req_ready = grant;
    assign accept      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_addr = i_req_rd_addr[k*AW +: AW];
                sel_data = i_req_rd_data[k*XLEN +: XLEN];
            end
        end
    end

    assign busy_vec = {busy_q, 1'b0};
    assign o_busy   = busy_vec;

    // WAW on the allocated rd is stalled too, so each register has at most one writer in flight.
    assign o_stall = i_alloc_en &
                     (busy_vec[i_rs1_addr] | busy_vec[i_rs2_addr] | busy_vec[i_alloc_rd_addr]);

    // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (accept) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (i_alloc_en && !o_stall) begin
            busy_nxt[i_alloc_rd_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt[NUM_REGS-1:1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_write_en <= 1'b0;
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
        end else if (accept) begin
            o_write_en <= (sel_addr != '0);
            o_rd_addr  <= sel_addr;
            o_rd_data  <= sel_data;
        end else begin
            o_write_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration order, write-port timing, scoreboard and stall.
module tb_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int AW      = 5;

    logic                    i_clk;
    logic                    i_rst;
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ*AW-1:0]   i_req_rd_addr;
    logic [NUM_REQ*XLEN-1:0] i_req_rd_data;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic                    o_write_en;
    logic [AW-1:0]           o_rd_addr;
    logic [XLEN-1:0]         o_rd_data;
    logic                    i_alloc_en;
    logic [AW-1:0]           i_alloc_rd_addr;
    logic [AW-1:0]           i_rs1_addr;
    logic [AW-1:0]           i_rs2_addr;
    logic                    o_stall;
    logic [31:0]             o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .AW      (AW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .i_req_rd_addr   (i_req_rd_addr),
        .i_req_rd_data   (i_req_rd_data),
        .o_req_ready     (o_req_ready),
        .o_write_en      (o_write_en),
        .o_rd_addr       (o_rd_addr),
        .o_rd_data       (o_rd_data),
        .i_alloc_en      (i_alloc_en),
        .i_alloc_rd_addr (i_alloc_rd_addr),
        .i_rs1_addr      (i_rs1_addr),
        .i_rs2_addr      (i_rs2_addr),
        .o_stall         (o_stall),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d);
        i_req_valid[k]              = v;
        i_req_rd_addr[k*AW +: AW]   = a;
        i_req_rd_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic alloc(input logic en, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        i_alloc_en      = en;
        i_alloc_rd_addr = rd;
        i_rs1_addr      = rs1;
        i_rs2_addr      = rs2;
    endtask

    initial begin
        i_rst         = 1'b1;
        i_req_valid   = '0;
        i_req_rd_addr = '0;
        i_req_rd_data = '0;
        alloc(1'b0, 5'd0, 5'd0, 5'd0);

        step();
        step();
        check("rst_write_en", 64'(o_write_en), 64'd0);
        check("rst_rd_addr",  64'(o_rd_addr),  64'd0);
        check("rst_rd_data",  64'(o_rd_data),  64'd0);
        check("rst_busy",     64'(o_busy),     64'd0);
        i_rst = 1'b0;

        // Round-robin with all three valid: grants 0,1,2,0, writes one cycle later.
        set_req(0, 1'b1, 5'd1, 32'hA0A0_0001);
        set_req(1, 1'b1, 5'd2, 32'hB0B0_0002);
        set_req(2, 1'b1, 5'd3, 32'hC0C0_0003);
        #1;
        check("rr_ready0", 64'(o_req_ready), 64'b001);
        step();
        check("rr_we0",    64'(o_write_en),  64'd1);
        check("rr_addr0",  64'(o_rd_addr),   64'd1);
        check("rr_data0",  64'(o_rd_data),   64'hA0A0_0001);
        check("rr_ready1", 64'(o_req_ready), 64'b010);
        step();
        check("rr_addr1",  64'(o_rd_addr),   64'd2);
        check("rr_data1",  64'(o_rd_data),   64'hB0B0_0002);
        check("rr_ready2", 64'(o_req_ready), 64'b100);
        step();
        check("rr_addr2",  64'(o_rd_addr),   64'd3);
        check("rr_data2",  64'(o_rd_data),   64'hC0C0_0003);
        check("rr_ready3", 64'(o_req_ready), 64'b001);
        step();
        i_req_valid = '0;
        #1;
        check("rr_addr3",  64'(o_rd_addr),   64'd1);
        check("rr_we3",    64'(o_write_en),  64'd1);
        check("idle_ready", 64'(o_req_ready), 64'd0);
        step();
        check("idle_we",   64'(o_write_en),  64'd0);
        check("idle_addr_hold", 64'(o_rd_addr), 64'd1);
        check("untracked_busy", 64'(o_busy), 64'd0);

        // RAW on x5: alloc, stall on rs1, LSU write-back clears it.
        alloc(1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        check("alloc5_stall", 64'(o_stall), 64'd0);
        step();
        check("alloc5_busy", 64'(o_busy), 64'h20);
        alloc(1'b1, 5'd9, 5'd5, 5'd0);
        #1;
        check("raw5_stall", 64'(o_stall), 64'd1);
        step();
        check("raw5_busy_hold", 64'(o_busy), 64'h20);
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("lsu_ready", 64'(o_req_ready), 64'b010);
        step();
        set_req(1, 1'b0, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("lsu_busy_clr", 64'(o_busy),     64'd0);
        check("lsu_stall_clr", 64'(o_stall),   64'd0);
        check("lsu_we",       64'(o_write_en), 64'd1);
        check("lsu_addr",     64'(o_rd_addr),  64'd5);
        check("lsu_data",     64'(o_rd_data),  64'hDEAD_BEEF);
        step();
        check("alloc9_busy", 64'(o_busy), 64'h200);

        // WAW on x7, and alloc of x0.
        alloc(1'b1, 5'd7, 5'd0, 5'd0);
        step();
        check("alloc7_busy", 64'(o_busy), 64'h280);
        #1;
        check("waw7_stall", 64'(o_stall), 64'd1);
        step();
        check("waw7_busy_hold", 64'(o_busy), 64'h280);
        alloc(1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        check("alloc0_stall", 64'(o_stall), 64'd0);
        step();
        check("alloc0_busy", 64'(o_busy), 64'h280);
        alloc(1'b0, 5'd0, 5'd0, 5'd0);

        // Pointer is at 2: requester 1 waits while 2 and then 0 are served.
        set_req(1, 1'b1, 5'd9, 32'h0000_0099);
        set_req(2, 1'b1, 5'd4, 32'h0000_0044);
        #1;
        check("hold_ready2", 64'(o_req_ready), 64'b100);
        step();
        set_req(2, 1'b0, 5'd4, 32'h0000_0044);
        set_req(0, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        check("hold_addr2", 64'(o_rd_addr), 64'd4);
        check("hold_ready0", 64'(o_req_ready), 64'b001);
        step();
        set_req(0, 1'b0, 5'd7, 32'h0000_0077);
        #1;
        check("hold_addr0", 64'(o_rd_addr), 64'd7);
        check("hold_busy7", 64'(o_busy), 64'h200);
        check("hold_ready1", 64'(o_req_ready), 64'b010);
        step();
        set_req(1, 1'b0, 5'd9, 32'h0000_0099);
        #1;
        check("hold_addr1", 64'(o_rd_addr), 64'd9);
        check("hold_data1", 64'(o_rd_data), 64'h99);
        check("hold_busy9", 64'(o_busy), 64'd0);
        step();
        check("hold_no_dup", 64'(o_write_en), 64'd0);

        // x0 destination: consumed, no write, pointer wraps to 0.
        set_req(2, 1'b1, 5'd0, 32'h0000_1234);
        #1;
        check("x0_ready", 64'(o_req_ready), 64'b100);
        step();
        set_req(2, 1'b0, 5'd0, 32'h0000_1234);
        #1;
        check("x0_we", 64'(o_write_en), 64'd0);
        check("x0_ready_drop", 64'(o_req_ready), 64'd0);
        check("x0_busy", 64'(o_busy), 64'd0);

        // Build busy=0x24 under traffic, then reset mid-stream.
        set_req(0, 1'b1, 5'd1, 32'h1111_1111);
        set_req(1, 1'b1, 5'd3, 32'h3333_3333);
        set_req(2, 1'b1, 5'd6, 32'h6666_6666);
        alloc(1'b1, 5'd2, 5'd0, 5'd0);
        #1;
        check("ptr0_ready", 64'(o_req_ready), 64'b001);
        step();
        alloc(1'b1, 5'd5, 5'd0, 5'd0);
        step();
        check("pre_rst_busy", 64'(o_busy), 64'h24);
        i_rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(o_busy), 64'd0);
        step();
        check("mid_rst_busy", 64'(o_busy),     64'd0);
        check("mid_rst_we",   64'(o_write_en), 64'd0);
        check("mid_rst_addr", 64'(o_rd_addr),  64'd0);
        i_rst = 1'b0;
        alloc(1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("post_rst_ready", 64'(o_req_ready), 64'b001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
